tcdm_cmd_split_ipa: RTL and testbench

//  Upstream stage of the TCDM beat unpacker. Accepts one TCDM transfer command (opc/len/add/sid)
//  and splits it into sub-commands that never cross a CHUNK_BYTES-aligned address boundary.

---
 rtl/tcdm_ipa_pkg.sv | 16 +
 rtl/tcdm_chunk_len_ipa.sv | 28 ++
 rtl/tcdm_cmd_split_ipa.sv | 104 ++++++++++
 tb/tb_tcdm_cmd_split_ipa.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_ipa_pkg.sv
// rtl/tcdm_ipa_pkg.sv - shared types and constants for the TCDM command splitter and beat unpacker
package tcdm_ipa_pkg;

    localparam int unsigned TCDM_BEAT_BYTES = 8;
    localparam int unsigned TCDM_LEN_W      = 15;
    localparam int unsigned TCDM_ADD_W      = 12;

    typedef logic [TCDM_LEN_W-1:0] tcdm_len_t;
    typedef logic [TCDM_ADD_W-1:0] tcdm_add_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } split_state_e;

endpackage

// File: rtl/tcdm_chunk_len_ipa.sv
// rtl/tcdm_chunk_len_ipa.sv - length (bytes-1) of the next chunk that stays inside one CHUNK_BYTES granule
module tcdm_chunk_len_ipa
    import tcdm_ipa_pkg::*;
#(
    parameter int TCDM_ADD_WIDTH  = 12,
    parameter int MCHAN_LEN_WIDTH = 15,
    parameter int CHUNK_BYTES     = 64
) (
    input  logic [TCDM_ADD_WIDTH-1:0]  cur_add,
    input  logic [MCHAN_LEN_WIDTH-1:0] rem,
    output logic [MCHAN_LEN_WIDTH-1:0] chunk_m1,
    output logic                       last
);

    localparam int CHUNK_LOG2 = $clog2(CHUNK_BYTES);

    logic [MCHAN_LEN_WIDTH-1:0] space_m1;
    logic                       unused_add_hi;

    // Only the offset inside the granule matters; the upper address bits are irrelevant here.
    assign unused_add_hi = ^cur_add[TCDM_ADD_WIDTH-1:CHUNK_LOG2];

    assign space_m1 = MCHAN_LEN_WIDTH'(CHUNK_BYTES - 1)
                    - MCHAN_LEN_WIDTH'(cur_add[CHUNK_LOG2-1:0]);
    assign last     = (rem <= space_m1);
    assign chunk_m1 = last ? rem : space_m1;

endmodule

// File: rtl/tcdm_cmd_split_ipa.sv
// rtl/tcdm_cmd_split_ipa.sv - splits TCDM transfers at CHUNK_BYTES boundaries; TCDM_SPLIT_DONE_EN adds a done pulse
module tcdm_cmd_split_ipa
    import tcdm_ipa_pkg::*;
#(
    parameter int TRANS_SID_WIDTH = 2,
    parameter int TCDM_ADD_WIDTH  = 12,
    parameter int TCDM_OPC_WIDTH  = 12,
    parameter int MCHAN_LEN_WIDTH = 15,
    parameter int CHUNK_BYTES     = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [TCDM_OPC_WIDTH-1:0]  in_opc_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] in_len_i,
    input  logic [TCDM_ADD_WIDTH-1:0]  in_add_i,
    input  logic [TRANS_SID_WIDTH-1:0] in_sid_i,
    input  logic                       in_req_i,
    output logic                       in_gnt_o,
    output logic [TCDM_OPC_WIDTH-1:0]  cmd_opc_o,
    output logic [MCHAN_LEN_WIDTH-1:0] cmd_len_o,
    output logic [TCDM_ADD_WIDTH-1:0]  cmd_add_o,
    output logic [TRANS_SID_WIDTH-1:0] cmd_sid_o,
    output logic                       cmd_req_o,
`ifdef TCDM_SPLIT_DONE_EN
    output logic                       trans_done_o,
    output logic [TRANS_SID_WIDTH-1:0] trans_done_sid_o,
`endif
    input  logic                       cmd_gnt_i
);

    split_state_e               cs;
    logic [MCHAN_LEN_WIDTH-1:0] rem_q;
    logic                       last_q;
    logic                       load;
    logic                       done_grant;
    logic [TCDM_ADD_WIDTH-1:0]  calc_add;
    logic [MCHAN_LEN_WIDTH-1:0] calc_rem;
    logic [MCHAN_LEN_WIDTH-1:0] calc_chunk_m1;
    logic                       calc_last;

    // cmd_add_o doubles as the current address and rem_q still includes the chunk on offer.
    assign done_grant = (cs == SPLIT) & cmd_gnt_i & last_q;
    assign in_gnt_o   = (cs == IDLE) | done_grant;
    assign load       = in_req_i & in_gnt_o;
    assign calc_add   = load ? in_add_i
                             : cmd_add_o + TCDM_ADD_WIDTH'(cmd_len_o) + TCDM_ADD_WIDTH'(1);
    assign calc_rem   = load ? in_len_i
                             : rem_q - cmd_len_o - MCHAN_LEN_WIDTH'(1);

    tcdm_chunk_len_ipa #(
        .TCDM_ADD_WIDTH  (TCDM_ADD_WIDTH),
        .MCHAN_LEN_WIDTH (MCHAN_LEN_WIDTH),
        .CHUNK_BYTES     (CHUNK_BYTES)
    ) u_chunk_len (
        .cur_add  (calc_add),
        .rem      (calc_rem),
        .chunk_m1 (calc_chunk_m1),
        .last     (calc_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs        <= IDLE;
            cmd_req_o <= 1'b0;
            cmd_opc_o <= '0;
            cmd_len_o <= '0;
            cmd_add_o <= '0;
            cmd_sid_o <= '0;
            rem_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            if (load || ((cs == SPLIT) && cmd_gnt_i && !last_q)) begin
                cs        <= SPLIT;
                cmd_req_o <= 1'b1;
                cmd_add_o <= calc_add;
                cmd_len_o <= calc_chunk_m1;
                rem_q     <= calc_rem;
                last_q    <= calc_last;
                if (load) begin
                    cmd_opc_o <= in_opc_i;
                    cmd_sid_o <= in_sid_i;
                end
            end else if (done_grant) begin
                cs        <= IDLE;
                cmd_req_o <= 1'b0;
            end
        end
    end

`ifdef TCDM_SPLIT_DONE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trans_done_o     <= 1'b0;
            trans_done_sid_o <= '0;
        end else begin
            trans_done_o <= done_grant;
            if (done_grant) begin
                trans_done_sid_o <= cmd_sid_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tcdm_cmd_split_ipa.sv
// tb/tb_tcdm_cmd_split_ipa.sv - scoreboard bench for tcdm_cmd_split_ipa (CHUNK_BYTES=64, 12-bit addresses)
module tb_tcdm_cmd_split_ipa;

    typedef struct packed {
        logic [11:0] add;
        logic [14:0] len;
        logic [11:0] opc;
        logic [1:0]  sid;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] in_opc = '0;
    logic [14:0] in_len = '0;
    logic [11:0] in_add = '0;
    logic [1:0]  in_sid = '0;
    logic        in_req = 1'b0;
    logic        in_gnt;
    logic [11:0] cmd_opc;
    logic [14:0] cmd_len;
    logic [11:0] cmd_add;
    logic [1:0]  cmd_sid;
    logic        cmd_req;
    logic        cmd_gnt = 1'b0;
`ifdef TCDM_SPLIT_DONE_EN
    logic        trans_done;
    logic [1:0]  trans_done_sid;
`endif

    cmd_t exp_q[$];
    cmd_t mon_exp;
    cmd_t mon_act;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tcdm_cmd_split_ipa #(
        .TRANS_SID_WIDTH (2),
        .TCDM_ADD_WIDTH  (12),
        .TCDM_OPC_WIDTH  (12),
        .MCHAN_LEN_WIDTH (15),
        .CHUNK_BYTES     (64)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .in_opc_i         (in_opc),
        .in_len_i         (in_len),
        .in_add_i         (in_add),
        .in_sid_i         (in_sid),
        .in_req_i         (in_req),
        .in_gnt_o         (in_gnt),
        .cmd_opc_o        (cmd_opc),
        .cmd_len_o        (cmd_len),
        .cmd_add_o        (cmd_add),
        .cmd_sid_o        (cmd_sid),
        .cmd_req_o        (cmd_req),
`ifdef TCDM_SPLIT_DONE_EN
        .trans_done_o     (trans_done),
        .trans_done_sid_o (trans_done_sid),
`endif
        .cmd_gnt_i        (cmd_gnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] add, input logic [14:0] len,
                         input logic [11:0] opc, input logic [1:0] sid);
        in_req = 1'b1;
        in_add = add;
        in_len = len;
        in_opc = opc;
        in_sid = sid;
    endtask

    task automatic expect_cmd(input logic [11:0] add, input logic [14:0] len,
                              input logic [11:0] opc, input logic [1:0] sid);
        cmd_t c;
        c.add = add;
        c.len = len;
        c.opc = opc;
        c.sid = sid;
        exp_q.push_back(c);
    endtask

    // Every granted sub-command is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && cmd_req && cmd_gnt) begin
            n_checks++;
            mon_act = '{add: cmd_add, len: cmd_len, opc: cmd_opc, sid: cmd_sid};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_cmd: got add=0x%0h len=0x%0h, none expected", cmd_add, cmd_len);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL cmd_compare: got add=0x%0h len=0x%0h opc=0x%0h sid=%0d expected add=0x%0h len=0x%0h opc=0x%0h sid=%0d",
                             mon_act.add, mon_act.len, mon_act.opc, mon_act.sid,
                             mon_exp.add, mon_exp.len, mon_exp.opc, mon_exp.sid);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_req", cmd_req, 0);
        chk("reset_in_gnt", in_gnt, 1);
        chk("reset_cmd_add", cmd_add, 0);
        chk("reset_cmd_len", cmd_len, 0);
        rst_n = 1'b1;
        tick();

        // 1: single chunk, one cycle accept-to-request
        cmd_gnt = 1'b1;
        expect_cmd(12'h000, 15'h0007, 12'h0A5, 2'd1);
        drive(12'h000, 15'h0007, 12'h0A5, 2'd1);
        #1 chk("t1_idle_gnt", in_gnt, 1);
        tick();
        in_req = 1'b0;
        #1 chk("t1_latency", cmd_req, 1);
        chk("t1_last_gnt", in_gnt, 1);
        tick();
        #1 chk("t1_back_idle", cmd_req, 0);
`ifdef TCDM_SPLIT_DONE_EN
        chk("t1_done_pulse", trans_done, 1);
        chk("t1_done_sid", trans_done_sid, 1);
`endif

        // 2: three chunks back to back
        expect_cmd(12'h038, 15'h0007, 12'h123, 2'd2);
        expect_cmd(12'h040, 15'h003F, 12'h123, 2'd2);
        expect_cmd(12'h080, 15'h0007, 12'h123, 2'd2);
        drive(12'h038, 15'h004F, 12'h123, 2'd2);
        tick();
        in_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_back_to_back_req", cmd_req, 1);
            chk("t2_in_gnt", in_gnt, (i == 2) ? 1 : 0);
            tick();
        end
        #1 chk("t2_done_idle", cmd_req, 0);

        // 3: stall on chunk 2
        expect_cmd(12'h038, 15'h0007, 12'h3C3, 2'd3);
        expect_cmd(12'h040, 15'h003F, 12'h3C3, 2'd3);
        expect_cmd(12'h080, 15'h0007, 12'h3C3, 2'd3);
        drive(12'h038, 15'h004F, 12'h3C3, 2'd3);
        tick();
        in_req = 1'b0;
        tick();
        cmd_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_stall_add", cmd_add, 32'h040);
            chk("t3_stall_len", cmd_len, 32'h3F);
            chk("t3_stall_req", cmd_req, 1);
            chk("t3_stall_in_gnt", in_gnt, 0);
            tick();
        end
        cmd_gnt = 1'b1;
        #1 chk("t3_mid_in_gnt", in_gnt, 0);
        tick();
        #1 chk("t3_last_in_gnt", in_gnt, 1);
        tick();
        #1 chk("t3_done_idle", cmd_req, 0);

        // 4: new transfer accepted on the last grant, no bubble
        expect_cmd(12'h000, 15'h0007, 12'h011, 2'd0);
        expect_cmd(12'h100, 15'h001F, 12'h022, 2'd1);
        drive(12'h000, 15'h0007, 12'h011, 2'd0);
        tick();
        drive(12'h100, 15'h001F, 12'h022, 2'd1);
        #1 chk("t4_b2b_gnt", in_gnt, 1);
        tick();
        in_req = 1'b0;
        #1 chk("t4_no_bubble", cmd_req, 1);
        chk("t4_next_add", cmd_add, 32'h100);
        tick();
        #1 chk("t4_done_idle", cmd_req, 0);

        // 5: address wrap
        expect_cmd(12'hFE0, 15'h001F, 12'h555, 2'd2);
        expect_cmd(12'h000, 15'h001F, 12'h555, 2'd2);
        drive(12'hFE0, 15'h003F, 12'h555, 2'd2);
        tick();
        in_req = 1'b0;
        #1 chk("t5_first_add", cmd_add, 32'hFE0);
        tick();
        #1 chk("t5_wrap_add", cmd_add, 32'h000);
        chk("t5_wrap_req", cmd_req, 1);
        tick();
        #1 chk("t5_done_idle", cmd_req, 0);

        // 6: asynchronous reset while a split is in flight
        cmd_gnt = 1'b0;
        drive(12'h038, 15'h004F, 12'h777, 2'd1);
        tick();
        in_req = 1'b0;
        #1 chk("t6_inflight_req", cmd_req, 1);
        rst_n = 1'b0;
        #1 chk("t6_async_req", cmd_req, 0);
        chk("t6_async_add", cmd_add, 0);
        chk("t6_reset_in_gnt", in_gnt, 1);
        tick();
        tick();
        rst_n = 1'b1;
        cmd_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t6_no_stale_req", cmd_req, 0);
            chk("t6_release_in_gnt", in_gnt, 1);
            tick();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
